// File: rtl/rect_draw_arbiter.sv
// Round-robin arbiter sharing one rectangle-drawing engine between NUM_REQ requesters.
// Latches the winner's rectangle, runs the engine draw/ready handshake and pulses done.
module rect_draw_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*8-1:0]    reqX,
  input  logic [NUM_REQ*9-1:0]    reqY,
  input  logic [NUM_REQ*8-1:0]    reqWidth,
  input  logic [NUM_REQ*9-1:0]    reqHeight,
  input  logic [NUM_REQ*16-1:0]   reqColour,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic                    busy,
  input  logic                    drawReady,
  output logic                    draw,
  output logic [7:0]              xOrigin,
  output logic [8:0]              yOrigin,
  output logic [7:0]              width,
  output logic [8:0]              height,
  output logic [15:0]             pixelData
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   winner_q, winner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               busy_q, busy_d;
  logic               draw_q, draw_d;
  logic [7:0]         x_q, x_d;
  logic [8:0]         y_q, y_d;
  logic [7:0]         w_q, w_d;
  logic [8:0]         h_q, h_d;
  logic [15:0]        col_q, col_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   ptr_next;

  // Scan from the pointer upward with wrap; first asserted request wins.
  always_comb begin
    int scan;
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = (int'(ptr_q) + i) % NUM_REQ;
      if (!win_found && req[PTR_W'(scan)]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(scan);
      end
    end
  end

  assign ptr_next = (winner_q == PTR_W'(NUM_REQ - 1)) ? '0 : winner_q + PTR_W'(1);

  always_comb begin
    int sel;
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    grant_d  = grant_q;
    done_d   = '0;
    busy_d   = busy_q;
    draw_d   = draw_q;
    x_d      = x_q;
    y_d      = y_q;
    w_d      = w_q;
    h_d      = h_q;
    col_d    = col_q;
    sel      = int'(win_idx);
    case (state_q)
      IDLE: begin
        draw_d = 1'b0;
        if (win_found && drawReady) begin
          winner_d         = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          busy_d           = 1'b1;
          x_d              = reqX[8*sel +: 8];
          y_d              = reqY[9*sel +: 9];
          w_d              = reqWidth[8*sel +: 8];
          h_d              = reqHeight[9*sel +: 9];
          col_d            = reqColour[16*sel +: 16];
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        // Only treat ready low as acceptance once draw has actually been presented.
        draw_d = 1'b1;
        if (draw_q && !drawReady) begin
          draw_d  = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        draw_d = 1'b0;
        if (drawReady) begin
          done_d[winner_q] = 1'b1;
          state_d          = DONE;
        end
      end
      DONE: begin
        draw_d  = 1'b0;
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = ptr_next;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      draw_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      draw_q   <= draw_d;
      x_q      <= x_d;
      y_q      <= y_d;
      w_q      <= w_d;
      h_q      <= h_d;
      col_q    <= col_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign draw      = draw_q;
  assign xOrigin   = x_q;
  assign yOrigin   = y_q;
  assign width     = w_q;
  assign height    = h_q;
  assign pixelData = col_q;

endmodule

// File: tb/tb_rect_draw_arbiter.sv
// Directed bench for rect_draw_arbiter with a simple draw-engine model on drawReady.
module tb_rect_draw_arbiter;

  localparam int N = 4;
  localparam int ENG_LAT = 14;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N*8-1:0]  reqX;
  logic [N*9-1:0]  reqY;
  logic [N*8-1:0]  reqWidth;
  logic [N*9-1:0]  reqHeight;
  logic [N*16-1:0] reqColour;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            busy;
  logic            drawReady;
  logic            draw;
  logic [7:0]      xOrigin;
  logic [8:0]      yOrigin;
  logic [7:0]      width;
  logic [8:0]      height;
  logic [15:0]     pixelData;

  int n_cmp = 0;
  int n_err = 0;

  logic eng_busy;
  logic eng_hold;
  int   eng_cnt;

  rect_draw_arbiter #(.NUM_REQ(N), .PTR_W(2)) dut (
    .clock(clock), .reset_n(reset_n), .req(req),
    .reqX(reqX), .reqY(reqY), .reqWidth(reqWidth), .reqHeight(reqHeight),
    .reqColour(reqColour), .grant(grant), .done(done), .busy(busy),
    .drawReady(drawReady), .draw(draw), .xOrigin(xOrigin), .yOrigin(yOrigin),
    .width(width), .height(height), .pixelData(pixelData)
  );

  always #5 clock = ~clock;

  // Engine: drops ready the edge after it sees draw, raises it ~15 cycles later.
  always @(posedge clock) begin
    if (!reset_n) begin
      eng_busy <= 1'b0;
      eng_cnt  <= 0;
    end else if (!eng_busy) begin
      if (draw) begin
        eng_busy <= 1'b1;
        eng_cnt  <= 0;
      end
    end else begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == ENG_LAT) eng_busy <= 1'b0;
    end
  end
  assign drawReady = !eng_busy && !eng_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_params(input int i, input logic [7:0] x, input logic [8:0] y,
                            input logic [7:0] w, input logic [8:0] h, input logic [15:0] c);
    reqX[8*i +: 8]       = x;
    reqY[9*i +: 9]       = y;
    reqWidth[8*i +: 8]   = w;
    reqHeight[9*i +: 9]  = h;
    reqColour[16*i +: 16] = c;
  endtask

  task automatic wait_grant(input logic [N-1:0] exp, input string tag);
    int n;
    n = 0;
    while (grant === '0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(grant), 32'(exp));
  endtask

  task automatic wait_done(input logic [N-1:0] exp, input string tag);
    int n;
    n = 0;
    while (done === '0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(done), 32'(exp));
  endtask

  task automatic wait_draw_fall(input string tag);
    int n;
    n = 0;
    while (draw !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    while (draw === 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 32'(draw), 32'd0);
  endtask

  initial begin
    logic [N-1:0] rr_order [6];
    rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    reset_n   = 1'b0;
    req       = '0;
    reqX      = '0;
    reqY      = '0;
    reqWidth  = '0;
    reqHeight = '0;
    reqColour = '0;
    eng_hold  = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_draw", 32'(draw), 32'd0);
    chk("rst_x", 32'(xOrigin), 32'd0);
    chk("rst_colour", 32'(pixelData), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Single request
    set_params(0, 8'd10, 9'd20, 8'd5, 9'd3, 16'hF800);
    req = 4'b0001;
    wait_grant(4'b0001, "single_grant");
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_x", 32'(xOrigin), 32'd10);
    chk("single_y", 32'(yOrigin), 32'd20);
    chk("single_w", 32'(width), 32'd5);
    chk("single_h", 32'(height), 32'd3);
    chk("single_colour", 32'(pixelData), 32'hF800);
    chk("single_draw_after_params", 32'(draw), 32'd0);
    @(negedge clock);
    chk("single_draw_high", 32'(draw), 32'd1);
    wait_done(4'b0001, "single_done");
    req = '0;
    @(negedge clock);
    chk("single_done_pulse", 32'(done), 32'd0);
    chk("single_busy_low", 32'(busy), 32'd0);
    chk("single_grant_low", 32'(grant), 32'd0);

    // Round robin from pointer 0 after a fresh reset
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    set_params(1, 8'd11, 9'd21, 8'd6, 9'd4, 16'h07E0);
    set_params(2, 8'd12, 9'd300, 8'd7, 9'd5, 16'h001F);
    set_params(3, 8'd13, 9'd23, 8'd0, 9'd0, 16'hFFFF);
    @(negedge clock);
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_grant(rr_order[k], $sformatf("rr_grant_%0d", k));
      wait_done(rr_order[k], $sformatf("rr_done_%0d", k));
      req = req & ~rr_order[k];
      @(negedge clock);
      if (k < 5) req = req | rr_order[k];
    end
    chk("rr_w_zero_passthru_absent", 32'(busy), 32'd0);
    req = '0;
    @(negedge clock);

    // Pointer skip: pointer now 2, requesters 0 and 1 asking
    req = 4'b0011;
    wait_grant(4'b0001, "skip_first");
    wait_done(4'b0001, "skip_first_done");
    req = 4'b0010;
    @(negedge clock);
    wait_grant(4'b0010, "skip_second");
    chk("skip_second_x", 32'(xOrigin), 32'd11);
    wait_done(4'b0010, "skip_second_done");
    req = '0;
    @(negedge clock);

    // Parameter isolation: pointer 2, only requester 0
    set_params(0, 8'd10, 9'd20, 8'd5, 9'd3, 16'hF800);
    req = 4'b0001;
    wait_grant(4'b0001, "iso_grant");
    wait_draw_fall("iso_in_busy");
    reqX[7:0] = 8'd99;
    req = '0;
    @(negedge clock);
    chk("iso_x_busy", 32'(xOrigin), 32'd10);
    wait_done(4'b0001, "iso_done");
    chk("iso_x_done", 32'(xOrigin), 32'd10);
    @(negedge clock);
    chk("iso_done_once", 32'(done), 32'd0);

    // Engine not ready: pointer 1, requester 2 asking
    eng_hold = 1'b1;
    req = 4'b0100;
    repeat (5) @(negedge clock);
    chk("nr_no_grant", 32'(grant), 32'd0);
    chk("nr_no_draw", 32'(draw), 32'd0);
    eng_hold = 1'b0;
    @(negedge clock);
    chk("nr_grant", 32'(grant), 32'b0100);
    chk("nr_w", 32'(width), 32'd7);
    chk("nr_y", 32'(yOrigin), 32'd300);
    wait_done(4'b0100, "nr_done");
    req = '0;
    @(negedge clock);

    // Reset mid-operation: pointer 3, requester 1 asking
    req = 4'b0010;
    wait_grant(4'b0010, "rm_grant");
    wait_draw_fall("rm_in_busy");
    chk("rm_busy_before", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rm_async_grant", 32'(grant), 32'd0);
    chk("rm_async_busy", 32'(busy), 32'd0);
    chk("rm_async_draw", 32'(draw), 32'd0);
    chk("rm_async_x", 32'(xOrigin), 32'd0);
    req = 4'b1010;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    wait_grant(4'b0010, "rm_first_after_reset");
    wait_done(4'b0010, "rm_done");
    req = '0;
    @(negedge clock);
    chk("rm_end_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rect_draw_arbiter.md
# rect_draw_arbiter

Round-robin arbiter that shares a single rectangle-drawing engine (the LT24 draw-square datapath) between up to `NUM_REQ` independent requesters, e.g. background, sprites and score overlay. It latches the winning requester's rectangle parameters and sequences the engine's `draw`/`ready` handshake. It returns a one-cycle `done` pulse to the requester when the engine has finished the rectangle. It sits between the game/application logic and the draw-square block; the LT24 pins are driven only by the draw-square block.

## Interface
- `NUM_REQ`, 4: number of requesters; range 2..8.
- `PTR_W`, 2: pointer width; must equal ceil(log2(`NUM_REQ`)), minimum 1.
- `clock` input 1: single system clock; all logic rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input `NUM_REQ`: per-requester draw request; level, held until matching `done`.
- `reqX` input `NUM_REQ*8`: x origins; requester i at bits [8i+7:8i].
- `reqY` input `NUM_REQ*9`: y origins; [9i+8:9i].
- `reqWidth` input `NUM_REQ*8`: widths.
- `reqHeight` input `NUM_REQ*9`: heights.
- `reqColour` input `NUM_REQ*16`: RGB565 pixel data.
- `grant` output `NUM_REQ`: one-hot; the requester currently owning the engine.
- `done` output `NUM_REQ`: one-cycle pulse on the owning requester's bit when its rectangle completes.
- `busy` output 1: high from grant until done.
- `drawReady` input 1: engine `ready`.
- `draw` output 1: engine `draw` strobe.
- `xOrigin` output 8, `yOrigin` output 9, `width` output 8, `height` output 9, `pixelData` output 16: latched parameters to the engine.

## Operation
- FSM states: IDLE, ISSUE, BUSY, DONE. Reset state is IDLE.
- Reset values: `grant`=0, `done`=0, `busy`=0, `draw`=0, all parameter outputs=0, pointer=0.
- IDLE
  - Wait for `|req` && `drawReady`.
  - Winner = first index with `req` set, scanning from pointer upward and wrapping modulo `NUM_REQ`.
  - On the winning edge:
    - Latch the winner's x/y/width/height/colour into the output registers.
    - Set `grant`=one-hot(winner) and `busy`=1.
    - Go to ISSUE.
- ISSUE
  - Hold `draw`=1.
  - When `drawReady`=0 (the engine has accepted the command), clear `draw` and go to BUSY.
- BUSY
  - Hold `draw`=0.
  - When `drawReady`=1, the engine has finished and re-armed. Go to DONE.
- DONE
  - Pulse `done[winner]` for exactly one cycle.
  - Clear `grant` and `busy`.
  - Set pointer = (winner+1) mod `NUM_REQ`.
  - Return to IDLE.
- Parameters are latched only at grant. Input changes during ISSUE/BUSY/DONE do not affect the outputs.
- Dropping `req[winner]` mid-draw does not abort; the rectangle completes and `done` still pulses.
- Non-granted requesters wait indefinitely. Round-robin guarantees each asserted requester is served within `NUM_REQ` grants.
- Width/height 0 is passed through unchanged; clamping is the requester's responsibility.
- `reset_n` low in any state: all outputs immediately return to reset values and the FSM goes to IDLE. The engine is reset from the same source.

## Timing
- Grant latency: `grant`/`busy`/parameters are valid on the first edge after `req` && `drawReady` are sampled high in IDLE.
- `draw` rises one edge after grant (ISSUE entry) and stays high until the edge after `drawReady` is sampled low.
- `draw` and the parameters are never changed in the same cycle that `draw` rises. Parameters are stable for at least one cycle before `draw` and for the whole command.
- `done` is high in the cycle after `drawReady` is sampled high in BUSY, for exactly one cycle.
- The next grant can occur on the edge after `done`. Minimum spacing is one IDLE cycle between consecutive commands.
- Simultaneous requests are resolved in a single cycle; there is no combinational path from `req` to `draw`.

## Test plan
- Single request
  - Stimulus: `req`=0001 with x=10, y=20, w=5, h=3, colour=16'hF800. Engine model drops `ready` 1 cycle after `draw` and raises it 15 cycles later.
  - Required response: `grant`=0001; outputs 10/20/5/3/F800; `draw` high ≥1 cycle; one `done[0]` pulse; `busy` low afterwards.
- Round-robin order
  - Stimulus: `req`=1111 held, with each requester's `req` reasserted after its `done`.
  - Required response: grant order 0,1,2,3,0,1.
- Pointer skip
  - Stimulus: pointer=2 (after serving requester 1), then `req`=0011.
  - Required response: requester 0 is granted before requester 1.
- Parameter isolation
  - Stimulus: change `reqX[0]` from 10 to 99 and drop `req[0]` during BUSY.
  - Required response: `xOrigin` stays 10; `done[0]` still pulses once.
- Engine not ready
  - Stimulus: `drawReady`=0 held while `req`=0100.
  - Required response: no grant and `draw`=0 until `drawReady` rises, then `grant`=0100 on the next edge.
- Reset mid-operation
  - Stimulus: assert `reset_n`=0 asynchronously in BUSY.
  - Required response: `draw`, `grant`, `busy`, `done` go to 0 without waiting for a clock edge; after release, the first grant goes to the lowest requesting index (pointer=0).
